// File: rtl/clkctl_pkg.sv
// Shared definitions for the CPU clock step controller: state encoding,
// default parameter values and button indices used by the top level.
package clkctl_pkg;

  // Default widths / debounce length
  localparam int DIV_W_DEFAULT     = 8;
  localparam int DB_CYCLES_DEFAULT = 16;

  // Controller state encoding (visible on the state output)
  localparam logic [1:0] STOP  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STEP  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  // Front-panel button slots in the conditioner array
  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;
  localparam int NUM_BTNS = 2;

  // True when the divided clock is being generated
  function automatic logic is_active(input logic [1:0] s);
    return s != STOP;
  endfunction

endpackage

// File: rtl/clock_step_controller_btn_cond.sv
// Front-panel button conditioner: two-flop synchronizer, debounce counter
// that accepts a new level only after DB_CYCLES consecutive samples that
// disagree with the current level, and a one-cycle pulse on each accepted
// press (debounced 0->1).
module btn_cond #(
  parameter int DB_CYCLES = 16
) (
  input  logic clock_in,
  input  logic nReset,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic differs;
  logic accept;

  // A sample that disagrees with the accepted level extends the run; the
  // run is accepted on its DB_CYCLES-th sample.
  assign differs = sync2_reg != level_reg;
  assign accept  = differs && (cnt_reg == CNT_W'(DB_CYCLES - 1));

  // Bring the raw button into the clock_in domain
  always_ff @(posedge clock_in or negedge nReset) begin
    if (!nReset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts it
  always_ff @(posedge clock_in or negedge nReset) begin
    if (!nReset) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else if (!differs) begin
      cnt_reg   <= '0;
    end else if (accept) begin
      cnt_reg   <= '0;
      level_reg <= sync2_reg;
    end else begin
      cnt_reg   <= cnt_reg + CNT_W'(1);
    end
  end

  // One-cycle strobe when a press (not a release) is accepted
  always_ff @(posedge clock_in or negedge nReset) begin
    if (!nReset) begin
      press_reg <= 1'b0;
    end else begin
      press_reg <= accept && sync2_reg;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/clock_step_controller.sv
// CPU clock controller: generates a programmable divided clock from
// clock_in with free-run, single-step and halt sequencing. Each cpu_clk
// half lasts shadow+1 cycles; shadow is reloaded from half_period only at
// the start of a period so a ratio change never produces a short half.
module clock_step_controller
  import clkctl_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic             clock_in,
  input  logic             nReset,
  input  logic [DIV_W-1:0] half_period,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_clk,
  output logic             cpu_tick,
  output logic             running,
  output logic [1:0]       state
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_press;

  logic [1:0]       state_reg,   state_next;
  logic [DIV_W-1:0] counter_reg, counter_next;
  logic [DIV_W-1:0] shadow_reg,  shadow_next;
  logic             clk_reg,     clk_next;
  logic             tick_reg,    tick_next;
  logic             running_reg, running_next;

  logic run_press;
  logic step_press;
  logic half_done;
  logic exit_req;

  assign btn_raw[BTN_RUN]  = run_btn;
  assign btn_raw[BTN_STEP] = step_btn;

  // One conditioner per front-panel button
  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_cond #(
        .DB_CYCLES(DB_CYCLES)
      ) u_btn_cond (
        .clock_in(clock_in),
        .nReset  (nReset),
        .raw     (btn_raw[gi]),
        .press   (btn_press[gi])
      );
    end
  endgenerate

  assign run_press  = btn_press[BTN_RUN];
  assign step_press = btn_press[BTN_STEP];

  // The current half ends on the cycle the counter reaches the shadow value
  assign half_done = counter_reg == shadow_reg;

  // Leaving RUN is requested by halt or a second run press; both mean DRAIN
  assign exit_req = (state_reg == RUN) && (halt || run_press);

  // Next-state logic for the sequencer, divide counter and output clock
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    shadow_next  = shadow_reg;
    clk_next     = clk_reg;
    tick_next    = 1'b0;

    case (state_reg)
      STOP: begin
        counter_next = '0;
        clk_next     = 1'b0;
        if (run_press || step_press) begin
          // Run has priority when both presses land together
          state_next   = run_press ? RUN : STEP;
          counter_next = '0;
          clk_next     = 1'b1;
          tick_next    = 1'b1;
          shadow_next  = half_period;
        end
      end

      default: begin
        if (half_done) begin
          counter_next = '0;
          if (clk_reg) begin
            // End of high half: always continue into the low half
            clk_next = 1'b0;
            if (exit_req) begin
              state_next = DRAIN;
            end
          end else if ((state_reg == RUN) && !exit_req) begin
            // End of period while free-running: start the next one
            clk_next    = 1'b1;
            tick_next   = 1'b1;
            shadow_next = half_period;
          end else begin
            // Step, drain, or a stop request on the final cycle: the
            // period has completed, so park with cpu_clk low
            state_next = STOP;
          end
        end else begin
          counter_next = counter_reg + DIV_W'(1);
          if (exit_req) begin
            state_next = DRAIN;
          end
        end
      end
    endcase

    running_next = is_active(state_next);
  end

  // Controller registers; reset forces cpu_clk low without waiting for a clock
  always_ff @(posedge clock_in or negedge nReset) begin
    if (!nReset) begin
      state_reg   <= STOP;
      counter_reg <= '0;
      shadow_reg  <= '0;
      clk_reg     <= 1'b0;
      tick_reg    <= 1'b0;
      running_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      shadow_reg  <= shadow_next;
      clk_reg     <= clk_next;
      tick_reg    <= tick_next;
      running_reg <= running_next;
    end
  end

  assign cpu_clk  = clk_reg;
  assign cpu_tick = tick_reg;
  assign running  = running_reg;
  assign state    = state_reg;

endmodule

// File: tb/tb_clock_step_controller.sv
// Self-checking bench for clock_step_controller. A behavioural model
// (button history windows plus a period-position clock model) runs in
// lockstep and every cycle's outputs are compared; directed steps add
// period/latency checks, followed by randomized button/halt activity.
module tb_clock_step_controller;

  localparam int DIV_W = 8;
  localparam int DB    = 4;

  logic             clock_in;
  logic             nReset;
  logic [DIV_W-1:0] half_period;
  logic             run_btn;
  logic             step_btn;
  logic             halt;
  logic             cpu_clk;
  logic             cpu_tick;
  logic             running;
  logic [1:0]       state;

  clock_step_controller #(
    .DIV_W    (DIV_W),
    .DB_CYCLES(DB)
  ) dut (
    .clock_in   (clock_in),
    .nReset     (nReset),
    .half_period(half_period),
    .run_btn    (run_btn),
    .step_btn   (step_btn),
    .halt       (halt),
    .cpu_clk    (cpu_clk),
    .cpu_tick   (cpu_tick),
    .running    (running),
    .state      (state)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model state: mode 0=STOP 1=RUN 2=STEP 3=DRAIN
  int mode_m, pos_m, half_m;
  bit clk_m, tick_m;
  bit lvl_run, lvl_step, pend_run, pend_step;
  bit hist_run[$];
  bit hist_step[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit all_eq(input bit q[$], input bit v);
    for (int i = 0; i < DB; i++) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mode_m = 0; pos_m = 0; half_m = 1; clk_m = 0; tick_m = 0;
    lvl_run = 0; lvl_step = 0; pend_run = 0; pend_step = 0;
    hist_run.delete();
    hist_step.delete();
    for (int i = 0; i < DB + 2; i++) begin
      hist_run.push_back(1'b0);
      hist_step.push_back(1'b0);
    end
  endtask

  // One clock_in edge of the spec: presses reach the sequencer one cycle
  // after the debouncer sees DB equal samples of the button that lag the
  // raw pin by two edges.
  task automatic model_edge();
    bit quit;
    tick_m = 0;
    if (mode_m == 0) begin
      clk_m = 0;
      if (pend_run || pend_step) begin
        mode_m = pend_run ? 1 : 2;
        pos_m  = 0;
        half_m = int'(half_period) + 1;
        clk_m  = 1;
        tick_m = 1;
      end
    end else begin
      quit = (mode_m == 1) && (halt || pend_run);
      pos_m++;
      if (pos_m == 2 * half_m) begin
        if (mode_m == 1 && !quit) begin
          pos_m  = 0;
          half_m = int'(half_period) + 1;
          tick_m = 1;
        end else begin
          mode_m = 0;
        end
      end else if (quit) begin
        mode_m = 3;
      end
      clk_m = (mode_m != 0) && (pos_m < half_m);
    end
    hist_run.push_back(run_btn);
    void'(hist_run.pop_front());
    hist_step.push_back(step_btn);
    void'(hist_step.pop_front());
    if (all_eq(hist_run, !lvl_run)) begin
      lvl_run = !lvl_run; pend_run = lvl_run;
    end else pend_run = 0;
    if (all_eq(hist_step, !lvl_step)) begin
      lvl_step = !lvl_step; pend_step = lvl_step;
    end else pend_step = 0;
  endtask

  task automatic cyc1();
    @(posedge clock_in);
    if (nReset) model_edge();
    else model_reset();
    #1;
    cyc++;
    check("cpu_clk",  {31'd0, cpu_clk},  {31'd0, clk_m});
    check("cpu_tick", {31'd0, cpu_tick}, {31'd0, tick_m});
    check("state",    {30'd0, state},    32'(mode_m));
    check("running",  {31'd0, running},  {31'd0, (mode_m != 0)});
  endtask

  task automatic idle(input int n);
    repeat (n) cyc1();
  endtask

  task automatic wait_tick(input int bound, output int t);
    bit found = 0;
    t = cyc;
    for (int k = 0; k < bound; k++) begin
      cyc1();
      if (cpu_tick === 1'b1) begin found = 1; t = cyc; break; end
    end
    check("tick_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_state(input logic [1:0] s, input int bound, output int t);
    bit found = 0;
    t = cyc;
    for (int k = 0; k < bound; k++) begin
      cyc1();
      if (state === s) begin found = 1; t = cyc; break; end
    end
    check("state_reached", {31'd0, found}, 32'd1);
  endtask

  // Cycles cpu_clk stays at lvl (counting the current sample) while active
  task automatic measure(input bit lvl, output int n);
    n = 0;
    while (cpu_clk === lvl && running === 1'b1 && n < 300) begin
      cyc1();
      n++;
    end
  endtask

  task automatic start_press(input bit use_step, output int t);
    idle(10);
    if (use_step) step_btn = 1; else run_btn = 1;
    wait_tick(40, t);
    run_btn = 0; step_btn = 0;
  endtask

  task automatic stop_run();
    int t;
    idle(10);
    run_btn = 1;
    wait_state(2'd0, 400, t);
    run_btn = 0;
    idle(10);
  endtask

  task automatic count_ticks(input int n, output int c);
    c = 0;
    repeat (n) begin
      cyc1();
      if (cpu_tick === 1'b1) c++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, hi, lo, c;
    nReset = 0; half_period = 8'd4; run_btn = 0; step_btn = 0; halt = 0;
    model_reset();
    idle(3);
    nReset = 1;
    idle(5);

    // Free run, divide-by-10
    half_period = 8'd4;
    start_press(0, t0);
    measure(1'b1, hi);
    measure(1'b0, lo);
    check("run_high_len", 32'(hi), 32'd5);
    check("run_low_len",  32'(lo), 32'd5);
    check("run_retick",   {31'd0, cpu_tick}, 32'd1);
    check("run_state",    {30'd0, state}, 32'd1);
    stop_run();

    // Single step, half_period=1
    half_period = 8'd1;
    start_press(1, t0);
    measure(1'b1, hi);
    measure(1'b0, lo);
    check("step_high_len", 32'(hi), 32'd2);
    check("step_low_len",  32'(lo), 32'd2);
    check("step_stopped",  {30'd0, state}, 32'd0);
    count_ticks(20, c);
    check("step_extra_ticks", 32'(c), 32'd0);

    // Halt during cycle 2 of the high half: full period then STOP
    half_period = 8'd4;
    start_press(0, t0);
    cyc1();
    halt = 1;
    cyc1();
    halt = 0;
    check("halt_drain", {30'd0, state}, 32'd3);
    wait_state(2'd0, 40, t1);
    check("halt_period", 32'(t1 - t0), 32'd10);
    count_ticks(20, c);
    check("halt_extra_ticks", 32'(c), 32'd0);

    // Ratio change mid-period applies from the next period
    half_period = 8'd4;
    start_press(0, t0);
    idle(3);
    half_period = 8'd0;
    wait_tick(30, t1);
    wait_tick(30, t2);
    wait_tick(30, t3);
    check("ratio_cur_period", 32'(t1 - t0), 32'd10);
    check("ratio_new_period", 32'(t2 - t1), 32'd2);
    check("ratio_new_period2", 32'(t3 - t2), 32'd2);
    stop_run();

    // Bouncing step button: three 3-cycle pulses do nothing
    repeat (3) begin
      step_btn = 1; idle(3);
      step_btn = 0; idle(3);
    end
    count_ticks(12, c);
    check("bounce_ticks", 32'(c), 32'd0);
    step_btn = 1;
    count_ticks(30, c);
    check("stable_step_ticks", 32'(c), 32'd1);
    step_btn = 0;
    idle(12);

    // Run and step together: run wins
    half_period = 8'd2;
    start_press(0, t0);
    check("prio_placeholder_state", {30'd0, state}, 32'd1);
    stop_run();
    run_btn = 1; step_btn = 1;
    wait_state(2'd1, 40, t0);
    check("prio_state", {30'd0, state}, 32'd1);
    run_btn = 0; step_btn = 0;
    stop_run();

    // Randomized activity checked against the model
    for (int it = 0; it < 60; it++) begin
      int act, w;
      half_period = 8'($urandom_range(0, 5));
      act = $urandom_range(0, 3);
      w   = $urandom_range(1, 9);
      case (act)
        0: begin run_btn = 1;  idle(w); run_btn = 0;  end
        1: begin step_btn = 1; idle(w); step_btn = 0; end
        2: begin halt = 1; idle($urandom_range(1, 3)); halt = 0; end
        default: idle(w);
      endcase
      idle($urandom_range(0, 12));
    end
    idle(40);

    // Asynchronous reset in RUN with cpu_clk high
    stop_run();
    half_period = 8'd4;
    start_press(0, t0);
    cyc1();
    check("pre_reset_clk", {31'd0, cpu_clk}, 32'd1);
    nReset = 0;
    #1;
    check("async_cpu_clk",  {31'd0, cpu_clk},  32'd0);
    check("async_cpu_tick", {31'd0, cpu_tick}, 32'd0);
    check("async_state",    {30'd0, state},    32'd0);
    check("async_running",  {31'd0, running},  32'd0);
    model_reset();
    idle(3);
    nReset = 1;
    idle(20);
    check("post_reset_state", {30'd0, state}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
